// File: rtl/alu_op_sequencer.sv
// Round-robin two-requester sequencer in front of the shared ALU slices.
// Issues one latched operation, waits ALU_LAT cycles, returns the result with a done pulse.
module alu_op_sequencer #(
    parameter int unsigned DW      = 3,
    parameter int unsigned RW      = 6,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [1:0]    op0,
    input  logic [1:0]    op1,
    input  logic [DW-1:0] a0,
    input  logic [DW-1:0] b0,
    input  logic [DW-1:0] a1,
    input  logic [DW-1:0] b1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          alu_en,
    output logic [1:0]    alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [RW-1:0] alu_dout,
    output logic          done,
    output logic          done_id,
    output logic [RW-1:0] dout,
    output logic          busy
);

    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e        state_q, state_d;
    logic          sel_id_q, sel_id_d;
    logic          last_id_q, last_id_d;
    logic [CW-1:0] lat_cnt_q, lat_cnt_d;
    logic [1:0]    op_q, op_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d;
    logic [RW-1:0] dout_q, dout_d;
    logic          done_id_q, done_id_d;
    logic          gnt0_q, gnt1_q, alu_en_q, done_q, busy_q;
    logic          pick;

    // Lone requester wins outright; on contention the one not served last wins.
    assign pick = req1 & (~req0 | ~last_id_q);

    always_comb begin
        state_d   = state_q;
        sel_id_d  = sel_id_q;
        last_id_d = last_id_q;
        lat_cnt_d = lat_cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        dout_d    = dout_q;
        done_id_d = done_id_q;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    sel_id_d  = pick;
                    last_id_d = pick;
                    op_d      = pick ? op1 : op0;
                    a_d       = pick ? a1 : a0;
                    b_d       = pick ? b1 : b0;
                    lat_cnt_d = CW'(ALU_LAT);
                    state_d   = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                lat_cnt_d = lat_cnt_q - CW'(1);
                if (lat_cnt_q == CW'(1)) begin
                    dout_d    = alu_dout;
                    done_id_d = sel_id_q;
                    state_d   = StDone;
                end
            end
            StDone: state_d = StIdle;
        endcase
    end

    // Strobes are registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sel_id_q  <= 1'b0;
            last_id_q <= 1'b1;
            lat_cnt_q <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            dout_q    <= '0;
            done_id_q <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            alu_en_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_id_q  <= sel_id_d;
            last_id_q <= last_id_d;
            lat_cnt_q <= lat_cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            dout_q    <= dout_d;
            done_id_q <= done_id_d;
            gnt0_q    <= (state_d == StIssue) && !sel_id_d;
            gnt1_q    <= (state_d == StIssue) && sel_id_d;
            alu_en_q  <= (state_d == StIssue);
            done_q    <= (state_d == StDone);
            busy_q    <= (state_d != StIdle);
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign alu_en  = alu_en_q;
    assign alu_op  = op_q;
    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign dout    = dout_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios plus random traffic against a
// transaction-level model; a second instance covers ALU_LAT = 3.
module tb_alu_op_sequencer;

    localparam int LAT1 = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 0, req1 = 0;
    logic [1:0] op0 = 0, op1 = 0;
    logic [2:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic       gnt0, gnt1, alu_en, done, done_id, busy;
    logic [1:0] alu_op;
    logic [2:0] alu_a, alu_b;
    logic [5:0] alu_dout, dout;

    logic       req13 = 0;
    logic [1:0] op13 = 0;
    logic [2:0] a13 = 0, b13 = 0;
    logic       g3_gnt0, g3_gnt1, alu_en3, done3, done_id3, busy3;
    logic [1:0] alu_op3;
    logic [2:0] alu_a3, alu_b3;
    logic [5:0] alu_dout3, dout3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DW(3), .RW(6), .ALU_LAT(LAT1)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1), .alu_en(alu_en),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_dout(alu_dout), .done(done),
        .done_id(done_id), .dout(dout), .busy(busy)
    );

    alu_op_sequencer #(.DW(3), .RW(6), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req0(1'b0), .req1(req13), .op0(2'b00), .op1(op13),
        .a0(3'b000), .b0(3'b000), .a1(a13), .b1(b13), .gnt0(g3_gnt0), .gnt1(g3_gnt1),
        .alu_en(alu_en3), .alu_op(alu_op3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_dout(alu_dout3), .done(done3), .done_id(done_id3), .dout(dout3), .busy(busy3)
    );

    function automatic logic [5:0] alu_fn(input logic [1:0] op, input logic [2:0] a, b);
        case (op)
            2'b00:   return {3'b000, ~(a ^ b)};
            2'b01:   return {3'b000, a & b};
            2'b10:   return {3'b000, a | b};
            default: return {a, b};
        endcase
    endfunction

    // ALU slices: result is valid only in the single cycle ALU_LAT after the enable edge.
    logic [5:0] s1_res = 0;
    logic       s1_v = 0;
    always @(posedge clk) begin
        s1_res <= alu_fn(alu_op, alu_a, alu_b);
        s1_v   <= alu_en;
    end
    assign alu_dout = s1_v ? s1_res : ~s1_res;

    logic [5:0] s3_r0 = 0, s3_r1 = 0, s3_r2 = 0;
    logic       s3_v0 = 0, s3_v1 = 0, s3_v2 = 0;
    always @(posedge clk) begin
        s3_r0 <= alu_fn(alu_op3, alu_a3, alu_b3);
        s3_v0 <= alu_en3;
        s3_r1 <= s3_r0;
        s3_v1 <= s3_v0;
        s3_r2 <= s3_r1;
        s3_v2 <= s3_v1;
    end
    assign alu_dout3 = s3_v2 ? s3_r2 : ~s3_r2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Transaction model: m_phase counts cycles since acceptance (0 = grant cycle).
    bit       m_active = 0;
    int       m_phase = 0;
    bit       m_last = 1'b1, m_sel = 0, m_done_id = 0;
    bit [1:0] m_op = 0;
    bit [2:0] m_a = 0, m_b = 0;
    bit [5:0] m_dout = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active  <= 0;
            m_phase   <= 0;
            m_last    <= 1'b1;
            m_sel     <= 0;
            m_done_id <= 0;
            m_op      <= 0;
            m_a       <= 0;
            m_b       <= 0;
            m_dout    <= 0;
        end else if (m_active) begin
            m_phase <= m_phase + 1;
            if (m_phase == LAT1) begin
                m_dout    <= alu_fn(m_op, m_a, m_b);
                m_done_id <= m_sel;
            end
            if (m_phase == LAT1 + 1) m_active <= 0;
        end else if (req0 || req1) begin
            m_active <= 1;
            m_phase  <= 0;
            m_sel    <= (req0 && req1) ? !m_last : req1;
            m_last   <= (req0 && req1) ? !m_last : req1;
            m_op     <= ((req0 && req1) ? !m_last : req1) ? op1 : op0;
            m_a      <= ((req0 && req1) ? !m_last : req1) ? a1 : a0;
            m_b      <= ((req0 && req1) ? !m_last : req1) ? b1 : b0;
        end
    end

    always @(negedge clk) begin
        chk("gnt0", gnt0, m_active && m_phase == 0 && !m_sel);
        chk("gnt1", gnt1, m_active && m_phase == 0 && m_sel);
        chk("alu_en", alu_en, m_active && m_phase == 0);
        chk("busy", busy, m_active);
        chk("done", done, m_active && m_phase == LAT1 + 1);
        chk("done_id", done_id, m_done_id);
        chk("dout", dout, m_dout);
        chk("alu_op", alu_op, m_op);
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
    end

    task automatic pulse_reset();
        @(posedge clk);
        #2 rst_n = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    int g0_first, g1_first, en_cnt;
    int dq[$];
    int gid[$];
    int gidx[$];

    initial begin
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset dout", dout, 0);
        chk("reset alu_a", alu_a, 0);
        chk("reset dut3 busy", busy3, 0);
        rst_n = 1;

        // Single XNOR: 101 xnor 011 = 001
        req0 = 1; op0 = 2'b00; a0 = 3'b101; b0 = 3'b011;
        @(negedge clk);
        chk("xnor gnt0 n+1", gnt0, 1);
        chk("xnor alu_en n+1", alu_en, 1);
        req0 = 0;
        @(negedge clk);
        chk("xnor no done n+2", done, 0);
        @(negedge clk);
        chk("xnor done n+3", done, 1);
        chk("xnor done_id n+3", done_id, 0);
        chk("xnor dout n+3", dout, 6'b000001);
        @(negedge clk);
        chk("xnor busy n+4", busy, 0);

        // Contention after reset
        pulse_reset();
        req0 = 1; op0 = 0; a0 = 3'b111; b0 = 3'b111;
        req1 = 1; op1 = 0; a1 = 3'b000; b1 = 3'b111;
        g0_first = -1; g1_first = -1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (gnt0 && g0_first < 0) g0_first = i;
            if (gnt1 && g1_first < 0) g1_first = i;
            if (done) begin
                dq.push_back(int'(done_id));
                chk("contention dout", dout, done_id ? 6'd0 : 6'd7);
            end
        end
        req0 = 0; req1 = 0;
        chk("contention first gnt0", g0_first, 1);
        chk("contention gnt1 spacing", g1_first - g0_first, 4);
        chk("contention done count", dq.size(), 4);
        for (int k = 0; k < dq.size() && k < 4; k++) chk("contention done_id seq", dq[k], k % 2);

        // Fairness: req1 alone, req0 rises during req1's WAIT
        @(negedge clk);
        req1 = 1; op1 = 2'b11; a1 = 3'b010; b1 = 3'b101;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            if (gnt0) begin gid.push_back(0); gidx.push_back(i); req0 = 0; end
            if (gnt1) begin gid.push_back(1); gidx.push_back(i); if (i == 13) req1 = 0; end
            if (i == 6) begin req0 = 1; op0 = 2'b01; a0 = 3'b110; b0 = 3'b011; end
        end
        chk("fair grant count", gid.size(), 4);
        for (int k = 0; k < gid.size() && k < 4; k++) begin
            chk("fair grant id", gid[k], (k == 2) ? 0 : 1);
            chk("fair grant cycle", gidx[k], 1 + 4 * k);
        end
        repeat (4) @(negedge clk);

        // Reset mid-WAIT
        req0 = 1; op0 = 2'b01; a0 = 3'b010; b0 = 3'b110;
        @(negedge clk);
        req0 = 0;
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst mid busy", busy, 0);
        chk("rst mid dout", dout, 0);
        chk("rst mid done_id", done_id, 0);
        chk("rst mid alu_a", alu_a, 0);
        chk("rst mid done", done, 0);
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst no done", done, 0);
        end
        req0 = 1; op0 = 2'b00; a0 = 3'b100; b0 = 3'b100;
        @(negedge clk);
        chk("post rst gnt0", gnt0, 1);
        req0 = 0;
        repeat (2) @(negedge clk);
        chk("post rst done", done, 1);
        chk("post rst dout", dout, 6'd7);
        @(negedge clk);

        // ALU_LAT = 3 instance
        req13 = 1; op13 = 2'b00; a13 = 3'b110; b13 = 3'b110;
        en_cnt = 0;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            en_cnt += int'(alu_en3);
            if (i == 1) chk("lat3 gnt1", g3_gnt1, 1);
            if (g3_gnt1) req13 = 0;
            chk("lat3 gnt0 never", g3_gnt0, 0);
            chk("lat3 done timing", done3, i == 5);
            if (i == 2) chk("lat3 alu_a held", alu_a3, 3'b110);
            if (i == 5) begin
                chk("lat3 dout", dout3, 6'b000111);
                chk("lat3 done_id", done_id3, 1);
            end
            if (i == 7) chk("lat3 idle busy", busy3, 0);
        end
        chk("lat3 alu_en cycles", en_cnt, 1);

        // Operand isolation: 001 | 010 = 011 from the latched operands
        req0 = 1; op0 = 2'b10; a0 = 3'b001; b0 = 3'b010;
        @(negedge clk);
        req0 = 0; op0 = 2'b11; a0 = 3'b111; b0 = 3'b101;
        @(negedge clk);
        chk("iso alu_a", alu_a, 3'b001);
        chk("iso alu_b", alu_b, 3'b010);
        chk("iso alu_op", alu_op, 2'b10);
        @(negedge clk);
        chk("iso dout", dout, 6'd3);
        @(negedge clk);
        chk("iso alu_a after", alu_a, 3'b001);

        // Random traffic, protocol-respecting, with occasional resets
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (req0 && gnt0) req0 = 1'($urandom_range(0, 1));
            else if (!req0 && $urandom_range(0, 2) == 0) req0 = 1;
            if (req0 && (gnt0 || !busy && $urandom_range(0, 1) == 0 && !req0)) req0 = 1;
            if (gnt0 || !req0) begin
                op0 = 2'($urandom); a0 = 3'($urandom); b0 = 3'($urandom);
            end
            if (req1 && gnt1) req1 = 1'($urandom_range(0, 1));
            else if (!req1 && $urandom_range(0, 2) == 0) req1 = 1;
            if (gnt1 || !req1) begin
                op1 = 2'($urandom); a1 = 3'($urandom); b1 = 3'($urandom);
            end
            if ($urandom_range(0, 149) == 0) begin
                #2 rst_n = 0;
                @(negedge clk);
                rst_n = 1;
            end
        end
        req0 = 0; req1 = 0;
        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
